// File: rtl/tx_cpl_mrd_engine_pkg.sv
// tx_cpl_mrd_engine_pkg: shared TLP fmt/type codes, FSM encoding and latched request records
package tx_cpl_mrd_engine_pkg;
    localparam logic [6:0] FMT_TYPE_CPLD  = 7'b1001010;
    localparam logic [6:0] FMT_TYPE_MRD32 = 7'b0000000;
    localparam logic [6:0] FMT_TYPE_MWR   = 7'b1000000;
    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CPL_B0 = 3'd1;
    localparam logic [2:0] ST_CPL_B1 = 3'd2;
    localparam logic [2:0] ST_MRD_B0 = 3'd3;
    localparam logic [2:0] ST_MRD_B1 = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;
    typedef struct packed {
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [6:0]  addr;
        logic [31:0] data;
    } cpl_fields_t;
    typedef struct packed {
        logic [29:0] addr;
        logic [9:0]  len;
        logic [7:0]  tag;
    } rd_fields_t;
endpackage

// File: rtl/tx_cpl_mrd_engine.sv
// tx_cpl_mrd_engine: serialises 3DW CplD completions and 3DW MRd32 requests onto a 64-bit TX AXI-S
module tx_cpl_mrd_engine
    import tx_cpl_mrd_engine_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
    output logic                      s_axis_tx_tlast,
    output logic                      s_axis_tx_tvalid,
    input  logic                      s_axis_tx_tready,
    input  logic                      req_compl_wd_i,
    output logic                      compl_done_o,
    input  logic [31:0]               tx_reg_data_i,
    input  logic [2:0]                req_tc_i,
    input  logic                      req_td_i,
    input  logic                      req_ep_i,
    input  logic [1:0]                req_attr_i,
    input  logic [9:0]                req_len_i,
    input  logic [15:0]               req_rid_i,
    input  logic [7:0]                req_tag_i,
    input  logic [6:0]                req_addr_i,
    input  logic [15:0]               completer_id_i,
    input  logic                      rd_req_i,
    input  logic [31:0]               rd_addr_i,
    input  logic [9:0]                rd_len_i,
    input  logic [7:0]                rd_tag_i,
    output logic                      rd_ack_o
);
    logic [2:0]                state_q, state_d;
    cpl_fields_t               cpl_q, cpl_d;
    rd_fields_t                rd_q, rd_d;
    logic [15:0]               cid_q, cid_d;
    logic [C_DATA_WIDTH-1:0]   tdata_d;
    logic [C_DATA_WIDTH/8-1:0] tkeep_d;
    logic                      beat_ok, take_cpl, take_rd;
    logic                      unused_inputs;

    // Completion length is always one DW and read addresses are DW aligned
    assign unused_inputs = ^{req_len_i, rd_addr_i[1:0]};
    assign beat_ok  = s_axis_tx_tvalid & s_axis_tx_tready;
    assign take_cpl = (state_q == ST_IDLE) & req_compl_wd_i;
    assign take_rd  = (state_q == ST_IDLE) & ~req_compl_wd_i & rd_req_i;
    assign cpl_d    = take_cpl ? {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_rid_i, req_tag_i, req_addr_i, tx_reg_data_i} : cpl_q;
    assign rd_d     = take_rd ? {rd_addr_i[31:2], rd_len_i, rd_tag_i} : rd_q;
    assign cid_d    = (take_cpl | take_rd) ? completer_id_i : cid_q;

    // Packet sequencing: completions win in IDLE, each beat waits for its handshake
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = take_cpl ? ST_CPL_B0 : take_rd ? ST_MRD_B0 : ST_IDLE;
            ST_CPL_B0: state_d = beat_ok ? ST_CPL_B1 : ST_CPL_B0;
            ST_CPL_B1: state_d = beat_ok ? ST_GAP : ST_CPL_B1;
            ST_MRD_B0: state_d = beat_ok ? ST_MRD_B1 : ST_MRD_B0;
            ST_MRD_B1: state_d = beat_ok ? ST_GAP : ST_MRD_B1;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Beat contents for next cycle; a stalled beat recomputes identical data from held state
    always_comb begin
        tdata_d = '0;
        tkeep_d = 8'hFF;
        case (state_d)
            ST_CPL_B0: tdata_d = {cid_d, CPL_STATUS_SC, 1'b0, 12'd4,
                                  1'b0, FMT_TYPE_CPLD, 1'b0, cpl_d.tc, 4'b0, cpl_d.td, cpl_d.ep, cpl_d.attr, 2'b00, 10'd1};
            ST_CPL_B1: tdata_d = {cpl_d.data, cpl_d.rid, cpl_d.tag, 1'b0, cpl_d.addr};
            ST_MRD_B0: tdata_d = {cid_d, rd_d.tag, (rd_d.len == 10'd1) ? 4'h0 : 4'hF, 4'hF,
                                  1'b0, FMT_TYPE_MRD32, 1'b0, 3'b000, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, rd_d.len};
            ST_MRD_B1: begin
                tdata_d = {32'h0, rd_d.addr, 2'b00};
                tkeep_d = 8'h0F;
            end
            default:   tkeep_d = 8'h00;
        endcase
    end

    // State, latched request fields and fully registered AXI-S/handshake outputs
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cpl_q            <= '0;
            rd_q             <= '0;
            cid_q            <= '0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tvalid <= 1'b0;
            compl_done_o     <= 1'b0;
            rd_ack_o         <= 1'b0;
        end else begin
            state_q          <= state_d;
            cpl_q            <= cpl_d;
            rd_q             <= rd_d;
            cid_q            <= cid_d;
            s_axis_tx_tdata  <= tdata_d;
            s_axis_tx_tkeep  <= tkeep_d;
            s_axis_tx_tlast  <= (state_d == ST_CPL_B1) | (state_d == ST_MRD_B1);
            s_axis_tx_tvalid <= (state_d != ST_IDLE) & (state_d != ST_GAP);
            compl_done_o     <= (state_q == ST_CPL_B1) & beat_ok;
            rd_ack_o         <= (state_q == ST_MRD_B1) & beat_ok;
        end
    end
endmodule

// File: tb/tb_tx_cpl_mrd_engine.sv
`timescale 1ns/100ps
// tb_tx_cpl_mrd_engine: directed vectors, stall/priority/reset sequences and random traffic vs a TLP-level model
module tb_tx_cpl_mrd_engine;
    typedef struct {
        bit          cpl;
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [15:0] cid;
        logic [31:0] raddr;
        logic [9:0]  rlen;
        logic [7:0]  rtag;
    } txn_t;
    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
    typedef struct { txn_t t; logic [63:0] b0; logic [63:0] b1; logic [7:0] k1; } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast, s_axis_tx_tvalid;
    logic        s_axis_tx_tready = 1'b1;
    logic        req_compl_wd_i = 1'b0, compl_done_o;
    logic [31:0] tx_reg_data_i = '0;
    logic [2:0]  req_tc_i = '0;
    logic        req_td_i = 1'b0, req_ep_i = 1'b0;
    logic [1:0]  req_attr_i = '0;
    logic [9:0]  req_len_i = '0;
    logic [15:0] req_rid_i = '0;
    logic [7:0]  req_tag_i = '0;
    logic [6:0]  req_addr_i = '0;
    logic [15:0] completer_id_i = '0;
    logic        rd_req_i = 1'b0, rd_ack_o;
    logic [31:0] rd_addr_i = '0;
    logic [9:0]  rd_len_i = '0;
    logic [7:0]  rd_tag_i = '0;

    int    checks = 0, errors = 0;
    int    done_cnt = 0, ack_cnt = 0, exp_done = 0, exp_ack = 0;
    beat_t exp_q[$];
    beat_t mb;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    bit          pstall = 1'b0;

    tx_cpl_mrd_engine #(.C_DATA_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
        .s_axis_tx_tready(s_axis_tx_tready),
        .req_compl_wd_i(req_compl_wd_i), .compl_done_o(compl_done_o), .tx_reg_data_i(tx_reg_data_i),
        .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i), .req_attr_i(req_attr_i),
        .req_len_i(req_len_i), .req_rid_i(req_rid_i), .req_tag_i(req_tag_i), .req_addr_i(req_addr_i),
        .completer_id_i(completer_id_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i), .rd_tag_i(rd_tag_i), .rd_ack_o(rd_ack_o)
    );

    always #2 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk_cpl(logic [2:0] tc, logic td, logic ep, logic [1:0] attr, logic [15:0] rid,
                                    logic [7:0] tag, logic [6:0] addr, logic [31:0] data, logic [15:0] cid);
        txn_t t;
        t = '{default: '0};
        t.cpl = 1'b1; t.tc = tc; t.td = td; t.ep = ep; t.attr = attr; t.rid = rid;
        t.tag = tag; t.addr = addr; t.data = data; t.cid = cid; t.len = 10'($urandom);
        return t;
    endfunction

    function automatic txn_t mk_rd(logic [31:0] raddr, logic [9:0] rlen, logic [7:0] rtag, logic [15:0] cid);
        txn_t t;
        t = '{default: '0};
        t.raddr = raddr; t.rlen = rlen; t.rtag = rtag; t.cid = cid;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        if ($urandom_range(0, 1) == 1)
            t = mk_cpl(3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
                       8'($urandom), 7'($urandom), $urandom, 16'($urandom));
        else
            t = mk_rd($urandom, ($urandom_range(0, 3) == 0) ? 10'd1 : 10'($urandom), 8'($urandom), 16'($urandom));
        return t;
    endfunction

    // Reference: build the TLP header DWs field by field with shifts and masks
    function automatic void model_push(input txn_t t);
        logic [31:0] dw0, dw1, dw2;
        if (t.cpl) begin
            dw0 = 32'h4A00_0001 | ({29'd0, t.tc} << 20) | ({31'd0, t.td} << 15) | ({31'd0, t.ep} << 14) | ({30'd0, t.attr} << 12);
            dw1 = ({16'd0, t.cid} << 16) + 32'd4;
            dw2 = ({16'd0, t.rid} << 16) | ({24'd0, t.tag} << 8) | {25'd0, t.addr};
            exp_q.push_back('{{dw1, dw0}, 8'hFF, 1'b0});
            exp_q.push_back('{{t.data, dw2}, 8'hFF, 1'b1});
        end else begin
            dw0 = {22'd0, t.rlen};
            dw1 = ({16'd0, t.cid} << 16) | ({24'd0, t.rtag} << 8) | ((t.rlen == 10'd1) ? 32'h0F : 32'hFF);
            exp_q.push_back('{{dw1, dw0}, 8'hFF, 1'b0});
            exp_q.push_back('{{32'd0, t.raddr & 32'hFFFF_FFFC}, 8'h0F, 1'b1});
        end
    endfunction

    task automatic apply_cpl(input txn_t t);
        req_tc_i = t.tc; req_td_i = t.td; req_ep_i = t.ep; req_attr_i = t.attr; req_len_i = t.len;
        req_rid_i = t.rid; req_tag_i = t.tag; req_addr_i = t.addr; tx_reg_data_i = t.data; completer_id_i = t.cid;
    endtask

    task automatic apply_rd(input txn_t t);
        rd_addr_i = t.raddr; rd_len_i = t.rlen; rd_tag_i = t.rtag; completer_id_i = t.cid;
    endtask

    task automatic scramble();
        req_tc_i = 3'($urandom); req_td_i = 1'($urandom); req_ep_i = 1'($urandom); req_attr_i = 2'($urandom);
        req_len_i = 10'($urandom); req_rid_i = 16'($urandom); req_tag_i = 8'($urandom); req_addr_i = 7'($urandom);
        tx_reg_data_i = $urandom; completer_id_i = 16'($urandom);
        rd_addr_i = $urandom; rd_len_i = 10'($urandom); rd_tag_i = 8'($urandom);
    endtask

    // mode 0: tready high, 1: random tready, 2: 5-cycle stall on first beat, 3: 5-cycle stall on last beat
    task automatic run_txn(input txn_t t, input int mode, output int cyc);
        int stall;
        stall = -1;
        cyc = 0;
        @(posedge clk_i); #1;
        s_axis_tx_tready = 1'b1;
        if (t.cpl) begin apply_cpl(t); req_compl_wd_i = 1'b1; exp_done++; end
        else begin apply_rd(t); rd_req_i = 1'b1; exp_ack++; end
        forever begin
            @(posedge clk_i); #1;
            cyc++;
            if (cyc == 1) scramble();
            if (t.cpl ? compl_done_o : rd_ack_o) break;
            if (cyc > 300) begin
                chk("pulse_timeout", 64'(cyc), 64'd0);
                break;
            end
            if (mode == 1) s_axis_tx_tready = ($urandom_range(0, 3) != 0);
            else if (mode >= 2) begin
                if (stall < 0 && s_axis_tx_tvalid && s_axis_tx_tlast == (mode == 3)) stall = 5;
                s_axis_tx_tready = !(stall > 0);
                if (stall > 0) stall--;
            end
        end
        req_compl_wd_i = 1'b0;
        rd_req_i = 1'b0;
        s_axis_tx_tready = 1'b1;
        @(posedge clk_i); #1;
        chk("pulse_width", {62'd0, compl_done_o, rd_ack_o}, 64'd0);
    endtask

    // Beat scoreboard, stall-stability check and pulse counting
    always @(negedge clk_i) begin
        if (pstall && rst_n)
            chk("held_beat", {s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata[53:0]},
                {1'b1, pl, pk, pd[53:0]});
        if (pstall && rst_n)
            chk("held_data_hi", s_axis_tx_tdata, pd);
        pstall = rst_n && s_axis_tx_tvalid && !s_axis_tx_tready;
        pd = s_axis_tx_tdata;
        pk = s_axis_tx_tkeep;
        pl = s_axis_tx_tlast;
        if (rst_n && s_axis_tx_tvalid && s_axis_tx_tready) begin
            if (exp_q.size() == 0) chk("extra_beat", s_axis_tx_tdata, 64'hx);
            else begin
                mb = exp_q.pop_front();
                chk("beat_data", s_axis_tx_tdata, mb.d);
                chk("beat_keep", {56'd0, s_axis_tx_tkeep}, {56'd0, mb.k});
                chk("beat_last", {63'd0, s_axis_tx_tlast}, {63'd0, mb.l});
            end
        end
        if (rst_n) begin
            done_cnt += int'(compl_done_o);
            ack_cnt  += int'(rd_ack_o);
        end
    end

    initial begin
        vec_t vecs[5];
        txn_t a, b;
        int   cyc, dcyc, acyc, d0, a0;
        vecs[0] = '{mk_cpl(3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h5A, 7'h14, 32'hDEADBEEF, 16'h0200),
                    64'h02000004_4A000001, 64'hDEADBEEF_01005A14, 8'hFF};
        vecs[1] = '{mk_rd(32'h1000_0040, 10'd32, 8'h03, 16'h0200),
                    64'h020003FF_00000020, 64'h00000000_10000040, 8'h0F};
        vecs[2] = '{mk_cpl(3'd7, 1'b1, 1'b1, 2'd3, 16'hFFFF, 8'hFF, 7'h7F, 32'h0, 16'hFFFF),
                    64'hFFFF0004_4A70F001, 64'h00000000_FFFFFF7F, 8'hFF};
        vecs[3] = '{mk_rd(32'hFFFF_FFFF, 10'd1, 8'hAB, 16'h1234),
                    64'h1234AB0F_00000001, 64'h00000000_FFFFFFFC, 8'h0F};
        vecs[4] = '{mk_rd(32'h0000_0003, 10'd0, 8'h7E, 16'h0200),
                    64'h02007EFF_00000000, 64'h00000000_00000000, 8'h0F};

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tvalid", {63'd0, s_axis_tx_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, s_axis_tx_tlast}, 64'd0);
        chk("rst_tkeep", {56'd0, s_axis_tx_tkeep}, 64'd0);
        chk("rst_tdata", s_axis_tx_tdata, 64'd0);
        chk("rst_pulses", {62'd0, compl_done_o, rd_ack_o}, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            exp_q.push_back('{vecs[i].b0, 8'hFF, 1'b0});
            exp_q.push_back('{vecs[i].b1, vecs[i].k1, 1'b1});
            run_txn(vecs[i].t, 0, cyc);
            chk("vec_latency", 64'(cyc), 64'd3);
            chk("vec_beats_left", 64'(exp_q.size()), 64'd0);
        end

        a = mk_cpl(3'd2, 1'b0, 1'b1, 2'd1, 16'hABCD, 8'h11, 7'h22, 32'hCAFEF00D, 16'h0300);
        model_push(a);
        run_txn(a, 2, cyc);
        chk("stall_b0_latency", 64'(cyc), 64'd8);
        chk("stall_b0_beats_left", 64'(exp_q.size()), 64'd0);
        b = mk_rd(32'h2000_1234, 10'd7, 8'h44, 16'h0300);
        model_push(b);
        run_txn(b, 3, cyc);
        chk("stall_b1_latency", 64'(cyc), 64'd8);
        chk("stall_b1_beats_left", 64'(exp_q.size()), 64'd0);

        a = mk_cpl(3'd1, 1'b0, 1'b0, 2'd2, 16'h0102, 8'h33, 7'h05, 32'h12345678, 16'h0400);
        b = mk_rd(32'h3000_0100, 10'd16, 8'h55, 16'h0400);
        model_push(a);
        model_push(b);
        d0 = done_cnt;
        a0 = ack_cnt;
        dcyc = -1;
        acyc = -1;
        @(posedge clk_i); #1;
        apply_cpl(a);
        apply_rd(b);
        req_compl_wd_i = 1'b1;
        rd_req_i = 1'b1;
        exp_done++;
        exp_ack++;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_i); #1;
            if (compl_done_o) begin dcyc = c; req_compl_wd_i = 1'b0; end
            if (rd_ack_o) begin acyc = c; rd_req_i = 1'b0; end
        end
        chk("prio_done_cycle", 64'(dcyc), 64'd3);
        chk("prio_ack_cycle", 64'(acyc), 64'd7);
        chk("prio_done_count", 64'(done_cnt - d0), 64'd1);
        chk("prio_ack_count", 64'(ack_cnt - a0), 64'd1);
        chk("prio_beats_left", 64'(exp_q.size()), 64'd0);

        a = mk_cpl(3'd4, 1'b1, 1'b0, 2'd0, 16'h0F0F, 8'h99, 7'h3C, 32'hA5A5A5A5, 16'h0500);
        model_push(a);
        @(posedge clk_i); #1;
        apply_cpl(a);
        req_compl_wd_i = 1'b1;
        s_axis_tx_tready = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("rst_mid_in_b1", {62'd0, s_axis_tx_tvalid, s_axis_tx_tlast}, 64'd3);
        s_axis_tx_tready = 1'b0;
        d0 = done_cnt;
        rst_n = 1'b0;
        #0.5;
        chk("rst_mid_tvalid", {63'd0, s_axis_tx_tvalid}, 64'd0);
        chk("rst_mid_tdata", s_axis_tx_tdata, 64'd0);
        chk("rst_mid_keep_last", {55'd0, s_axis_tx_tkeep, s_axis_tx_tlast}, 64'd0);
        req_compl_wd_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mid_no_done", {63'd0, compl_done_o}, 64'd0);
        chk("rst_mid_done_cnt", 64'(done_cnt - d0), 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        model_push(a);
        run_txn(a, 0, cyc);
        chk("rst_retry_latency", 64'(cyc), 64'd3);
        chk("rst_retry_beats_left", 64'(exp_q.size()), 64'd0);

        for (int n = 0; n < 40; n++) begin
            a = rnd_txn();
            model_push(a);
            run_txn(a, 1, cyc);
            chk("rand_beats_left", 64'(exp_q.size()), 64'd0);
        end

        chk("total_done", 64'(done_cnt), 64'(exp_done));
        chk("total_ack", 64'(ack_cnt), 64'(exp_ack));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_cpl_mrd_engine.md
TX_CPL_MRD_ENGINE -- requirements
Module: tx_cpl_mrd_engine

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, TX AXI-S data width; only 64 is supported.
REQ-002 SHALL have ports: clk_i in 1, 250 MHz PCIe user clock; rst_n in 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: s_axis_tx_tdata out 64; s_axis_tx_tkeep out 8; s_axis_tx_tlast out 1; s_axis_tx_tvalid out 1; s_axis_tx_tready in 1 (PCIe core TX).
REQ-004 SHALL have ports: req_compl_wd_i in 1, completion request, held high until compl_done_o; compl_done_o out 1, one-cycle done pulse; tx_reg_data_i in 32, completion payload.
REQ-005 SHALL have request-field inputs: req_tc_i 3, req_td_i 1, req_ep_i 1, req_attr_i 2, req_len_i 10, req_rid_i 16, req_tag_i 8, req_addr_i 7.
REQ-006 SHALL have ports: completer_id_i in 16, bus/dev/func of this endpoint.
REQ-007 SHALL have ports: rd_req_i in 1, DMA read request level; rd_addr_i in 32, byte address; rd_len_i in 10, length in DW (0 = 1024); rd_tag_i in 8; rd_ack_o out 1, one-cycle accept pulse.

Function
REQ-008 SHALL use states IDLE, CPL_B0, CPL_B1, MRD_B0, MRD_B1, GAP.
REQ-009 In IDLE, req_compl_wd_i high SHALL latch all completion inputs and go to CPL_B0; otherwise rd_req_i high SHALL latch rd_* and go to MRD_B0; completion has strict priority.
REQ-010 Latched fields SHALL be used for the whole packet; input changes after latch SHALL be ignored.
REQ-011 CPL_B0 SHALL drive tdata = {DW1,DW0}, tkeep 8'hFF, tlast 0; DW0 = {0, fmt 2'b10, type 5'b01010, 0, tc, 4'b0, td, ep, attr, 2'b00, len 10'd1}; DW1 = {completer_id, status 3'b000, bcm 0, byte count 12'd4}.
REQ-012 CPL_B1 SHALL drive tdata = {tx_reg_data, DW2}, tkeep 8'hFF, tlast 1; DW2 = {rid, tag, 0, req_addr[6:0]}.
REQ-013 MRD_B0 SHALL drive DW0 = {0, fmt 2'b00, type 5'b00000, 0, tc 000, 4'b0, td 0, ep 0, attr 00, 2'b00, rd_len} and DW1 = {completer_id, rd_tag, lastBE, firstBE 4'hF}, with lastBE = 4'hF if rd_len != 1 else 4'h0; tkeep 8'hFF, tlast 0.
REQ-014 MRD_B1 SHALL drive tdata = {32'h0, rd_addr[31:2], 2'b00}, tkeep 8'h0F, tlast 1.
REQ-015 tvalid SHALL be high exactly in the four B-states; each beat advances only on tvalid & tready; tdata/tkeep/tlast SHALL be held stable while tready is low.
REQ-016 Accepting CPL_B1 SHALL go to GAP with compl_done_o = 1 for exactly that GAP cycle; accepting MRD_B1 SHALL go to GAP with rd_ack_o = 1 for that cycle.
REQ-017 GAP SHALL last one cycle, ignore all requests, and return to IDLE, so that a requester clearing its level request on the done/ack pulse is never re-served.
REQ-018 Minimum packet cost SHALL be 4 cycles: IDLE, B0, B1, GAP; back-to-back requests SHALL be served every 4 cycles under continuous tready.
REQ-019 Outputs SHALL be registered; there is no combinational path from tready to tdata.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, tvalid 0, tlast 0, tkeep 8'h00, tdata 0, compl_done_o 0, rd_ack_o 0, and clear latched fields.
REQ-021 Reset mid-packet SHALL abandon the packet without generating done/ack; after release, the block SHALL restart from IDLE on the next rising edge.

Structure
REQ-022 A shared package SHALL hold the fmt/type constants (CPLD 7'b1001010, MRD32 7'b0000000, MWR 7'b1000000), the state encoding, and the completion status code.
REQ-023 The block SHALL be a single module with no sub-module; header formation is inline.

Verification
REQ-024 Completion with req_compl_wd_i=1, tag 8'h5A, rid 16'h0100, addr 7'h14, data 32'hDEADBEEF, completer 16'h0200, tready=1 -> beat0 {32'h02000004, 32'h4A000001}, beat1 {32'hDEADBEEF, 32'h01005A14}, compl_done_o pulse on cycle 4.
REQ-025 Read with rd_addr 32'h1000_0040, rd_len 10'd32, rd_tag 8'h03 -> DW0 32'h00000020, DW1 32'h020003FF, beat1 tkeep 8'h0F, tdata[31:0] 32'h10000040, rd_ack_o single pulse.
REQ-026 req_compl_wd_i and rd_req_i rise together -> CPLD sent first, then MRD starts 1 GAP cycle later; each receives exactly one pulse.
REQ-027 tready low for 5 cycles during CPL_B0 and MRD_B1 -> tdata/tlast held constant; no beat duplicated or dropped.
REQ-028 rst_n asserted during CPL_B1 -> tvalid low asynchronously, no compl_done_o; a re-presented request after release is sent in full.
